// File: rtl/pixel_streamer.sv
// pixel_streamer: raster frame reader from sync-read memory, emitting a valid-qualified pixel stream with sideband
module pixel_streamer #(
  parameter int I_F_BW   = 8,
  parameter int IX       = 28,
  parameter int IY       = 28,
  parameter int ADDR_BW  = $clog2(IX*IY),
  parameter int LINE_GAP = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_hold,
  output logic                  o_mem_en,
  output logic [ADDR_BW-1:0]    o_mem_addr,
  input  logic [I_F_BW-1:0]     i_mem_data,
  output logic                  o_out_valid,
  output logic [I_F_BW-1:0]     o_out_pixel,
  output logic [$clog2(IX)-1:0] o_x,
  output logic [$clog2(IY)-1:0] o_y,
  output logic                  o_sof,
  output logic                  o_eol,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int XW = $clog2(IX);
  localparam int YW = $clog2(IY);
  localparam int GW = LINE_GAP > 1 ? $clog2(LINE_GAP) : 1;
  typedef enum logic [2:0] {IDLE, RUN, GAP, DRAIN, DONE} state_t;
  state_t state;
  logic [XW-1:0] nx, fx, x1;
  logic [YW-1:0] ny, fy, y1;
  logic [ADDR_BW-1:0] na;
  logic [GW-1:0] gc;
  logic v1, sof1, eol1, issue, last_x, last_y;
  // nx/ny/na point at the next fetch; fx/fy tag the fetch currently on the memory bus
  assign last_x = nx == XW'(IX-1);
  assign last_y = ny == YW'(IY-1);
  assign issue  = (state == RUN && !i_hold) || (state == IDLE && i_start);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      o_mem_en <= 1'b0;
      o_mem_addr <= '0;
      nx <= '0;
      ny <= '0;
      na <= '0;
      fx <= '0;
      fy <= '0;
      gc <= '0;
      v1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
      sof1 <= 1'b0;
      eol1 <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_pixel <= '0;
      o_x <= '0;
      o_y <= '0;
      o_sof <= 1'b0;
      o_eol <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_mem_en <= issue;
      o_done <= 1'b0;
      v1 <= o_mem_en;
      x1 <= fx;
      y1 <= fy;
      sof1 <= o_mem_en && fx == '0 && fy == '0;
      eol1 <= o_mem_en && fx == XW'(IX-1);
      o_out_valid <= v1;
      o_x <= x1;
      o_y <= y1;
      o_sof <= sof1;
      o_eol <= eol1;
      if (v1) o_out_pixel <= i_mem_data;
      if (issue) begin
        o_busy <= 1'b1;
        o_mem_addr <= na;
        fx <= nx;
        fy <= ny;
        na <= na + 1'b1;
        nx <= last_x ? '0 : nx + 1'b1;
        ny <= last_x ? ny + 1'b1 : ny;
        gc <= GW'(LINE_GAP - 1);
        state <= last_x && last_y ? DRAIN : (last_x && LINE_GAP > 0) ? GAP : RUN;
      end else
        case (state)
          GAP: if (gc == '0) state <= RUN; else gc <= gc - 1'b1;
          DRAIN: if (!o_mem_en && !v1) begin
            state <= DONE;
            o_done <= 1'b1;
          end
          DONE: begin
            state <= IDLE;
            o_busy <= 1'b0;
            nx <= '0;
            ny <= '0;
            na <= '0;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_pixel_streamer.sv
// tb_pixel_streamer: scoreboard bench; instance 0 has LINE_GAP=0, instance 1 has LINE_GAP=3
module tb_pixel_streamer;
  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  pix;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        sof;
    logic        eol;
  } beat_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int nchk = 0, nfail = 0;
  logic rst[2], start[2], hold[2], en[2], valid[2], sof[2], eol[2], busy[2], done[2];
  logic [9:0] addr[2];
  logic [7:0] mdata[2], pix[2];
  logic [4:0] ox[2], oy[2];
  beat_t q[2][$];
  int dq[2][$];
  for (genvar g = 0; g < 2; g++) begin : u
    beat_t a, e;
    int d;
    pixel_streamer #(.LINE_GAP(3*g)) dut (
      .clk(clk), .reset(rst[g]), .i_start(start[g]), .i_hold(hold[g]),
      .o_mem_en(en[g]), .o_mem_addr(addr[g]), .i_mem_data(mdata[g]),
      .o_out_valid(valid[g]), .o_out_pixel(pix[g]), .o_x(ox[g]), .o_y(oy[g]),
      .o_sof(sof[g]), .o_eol(eol[g]), .o_busy(busy[g]), .o_done(done[g])
    );
    always @(posedge clk) mdata[g] <= addr[g][7:0];
    always @(negedge clk) begin
      if (valid[g]) begin
        a = {32'(cyc), pix[g], 8'(ox[g]), 8'(oy[g]), sof[g], eol[g]};
        nchk++;
        if (q[g].size() == 0) begin
          nfail++;
          $display("FAIL beat%0d unexpected: got cyc=%0d pix=%0d x=%0d y=%0d, required no beat", g, cyc, pix[g], ox[g], oy[g]);
        end else begin
          e = q[g].pop_front();
          if (a !== e) begin
            nfail++;
            $display("FAIL beat%0d: got cyc=%0d pix=%0d x=%0d y=%0d sof=%b eol=%b, required cyc=%0d pix=%0d x=%0d y=%0d sof=%b eol=%b",
                     g, a.cyc, a.pix, a.x, a.y, a.sof, a.eol, e.cyc, e.pix, e.x, e.y, e.sof, e.eol);
          end
        end
      end
      if (done[g]) begin
        nchk++;
        if (dq[g].size() == 0) begin
          nfail++;
          $display("FAIL done%0d unexpected: got pulse at cyc=%0d, required none", g, cyc);
        end else begin
          d = dq[g].pop_front();
          if (d != cyc) begin
            nfail++;
            $display("FAIL done%0d: got cyc=%0d, required cyc=%0d", g, cyc, d);
          end
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string nm, input int act, input int req);
    nchk++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask
  // expected beat k lands 3 cycles after start, plus row gaps and any hold shift
  task automatic push_frame(input int i, input int t0, input int hk, input int hl, input int nk);
    beat_t b;
    int c = 0;
    for (int k = 0; k < nk; k++) begin
      c = t0 + 3 + k + 3 * i * (k / 28) + (k >= hk ? hl : 0);
      b = {32'(c), 8'(k % 256), 8'(k % 28), 8'(k / 28), k == 0, k % 28 == 27};
      q[i].push_back(b);
    end
    if (nk == 784) dq[i].push_back(c + 1);
  endtask
  task automatic pulse(input int i);
    start[i] = 1'b1;
    step(1);
    start[i] = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      start[i] = 1'b0;
      hold[i] = 1'b0;
    end
    step(3);
    chk("rst_ctrl", {en[0], valid[0], sof[0], eol[0], busy[0], done[0], addr[0]}, 0);
    chk("rst_data", {pix[0], ox[0], oy[0]}, 0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    step(2);
    fork
      begin : b0
        int t;
        t = cyc;
        push_frame(0, t, 99999, 0, 784);
        chk("busy_c0", busy[0], 0);
        pulse(0);
        chk("busy_c1", busy[0], 1);
        chk("en_c1", en[0], 1);
        chk("addr_c1", addr[0], 0);
        step(99);
        pulse(0);
        step(686);
        chk("busy_c787", busy[0], 1);
        start[0] = 1'b1;
        step(1);
        chk("busy_c788", busy[0], 0);
        push_frame(0, t + 788, 99999, 0, 784);
        step(1);
        start[0] = 1'b0;
        step(800);
        t = cyc;
        push_frame(0, t, 10, 5, 784);
        pulse(0);
        step(9);
        chk("hold_en_c10", en[0], 1);
        hold[0] = 1'b1;
        step(5);
        hold[0] = 1'b0;
        chk("hold_en_c15", en[0], 0);
        step(1);
        chk("hold_en_c16", en[0], 1);
        chk("hold_addr_c16", addr[0], 10);
        step(790);
        t = cyc;
        push_frame(0, t, 99999, 0, 397);
        pulse(0);
        step(399);
        rst[0] = 1'b1;
        #1;
        chk("midrst_ctrl", {en[0], valid[0], sof[0], eol[0], busy[0], done[0], addr[0]}, 0);
        chk("midrst_data", {pix[0], ox[0], oy[0]}, 0);
        step(2);
        rst[0] = 1'b0;
        step(40);
        chk("postrst_busy", busy[0], 0);
        chk("postrst_en", en[0], 0);
        t = cyc;
        push_frame(0, t, 99999, 0, 784);
        pulse(0);
        step(800);
      end
      begin : b1
        int t;
        t = cyc;
        push_frame(1, t, 99999, 0, 784);
        pulse(1);
        step(880);
        t = cyc;
        push_frame(1, t, 28, 3, 784);
        pulse(1);
        step(28);
        hold[1] = 1'b1;
        step(5);
        hold[1] = 1'b0;
        chk("gaphold_en_c34", en[1], 0);
        step(1);
        chk("gaphold_en_c35", en[1], 1);
        chk("gaphold_addr_c35", addr[1], 28);
        step(850);
      end
    join
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("beats_left%0d", i), q[i].size(), 0);
      chk($sformatf("done_left%0d", i), dq[i].size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
